// File: rtl/alu_core.sv
// 64-bit SIMD vector ALU: element-wise logic, add/sub, multiply, shifts and
// half-swap on 8/16/32/64-bit lanes, with a single registered result.
module alu_core #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:DW-1] oprA,
  input  logic [0:DW-1] oprB,
  input  logic [0:4]    shift_amount,
  input  logic [0:5]    op,
  input  logic [0:1]    ww,
  output logic [0:DW-1] result
);

  localparam logic [5:0] OP_VNOP   = 6'h00;
  localparam logic [5:0] OP_VAND   = 6'h01;
  localparam logic [5:0] OP_VOR    = 6'h02;
  localparam logic [5:0] OP_VXOR   = 6'h03;
  localparam logic [5:0] OP_VNOT   = 6'h04;
  localparam logic [5:0] OP_VMOV   = 6'h05;
  localparam logic [5:0] OP_VADD   = 6'h06;
  localparam logic [5:0] OP_VSUB   = 6'h07;
  localparam logic [5:0] OP_VMULEU = 6'h08;
  localparam logic [5:0] OP_VMULOU = 6'h09;
  localparam logic [5:0] OP_VSLL   = 6'h0A;
  localparam logic [5:0] OP_VSRL   = 6'h0B;
  localparam logic [5:0] OP_VSRA   = 6'h0C;
  localparam logic [5:0] OP_VRTTH  = 6'h0D;
  localparam logic [5:0] OP_VSLLI  = 6'h0E;
  localparam logic [5:0] OP_VSRLI  = 6'h0F;

  // Descending internal view: element 0 (big-endian bit 0) lands in the MSBs.
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [4:0]    shamt;
  logic [5:0]    opc;
  logic [1:0]    wsel;

  assign a     = oprA;
  assign b     = oprB;
  assign shamt = shift_amount;
  assign opc   = op;
  assign wsel  = ww;

  logic [DW-1:0] lane_res [4];
  logic [DW-1:0] mul_even [4];
  logic [DW-1:0] mul_odd  [4];
  logic [DW-1:0] result_d;
  logic [DW-1:0] result_q;

  // One datapath copy per element width; lane l holds element N-1-l.
  for (genvar g = 0; g < 4; g++) begin : g_width
    localparam int unsigned W  = 8 << g;
    localparam int unsigned N  = DW / W;
    localparam int unsigned SW = $clog2(W);

    for (genvar l = 0; l < N; l++) begin : g_lane
      logic [W-1:0]  ea;
      logic [W-1:0]  eb;
      logic [W-1:0]  er;
      logic [SW-1:0] cnt_b;
      logic [SW-1:0] cnt_i;

      assign ea    = a[l*W +: W];
      assign eb    = b[l*W +: W];
      assign cnt_b = eb[SW-1:0];
      assign cnt_i = SW'(shamt);

      always_comb begin
        er = '0;
        case (opc)
          OP_VNOP:  er = '0;
          OP_VAND:  er = ea & eb;
          OP_VOR:   er = ea | eb;
          OP_VXOR:  er = ea ^ eb;
          OP_VNOT:  er = ~ea;
          OP_VMOV:  er = ea;
          OP_VADD:  er = ea + eb;
          OP_VSUB:  er = ea - eb;
          OP_VSLL:  er = ea << cnt_b;
          OP_VSRL:  er = ea >> cnt_b;
          OP_VSRA:  er = W'($signed(ea) >>> cnt_b);
          OP_VRTTH: er = {ea[W/2-1:0], ea[W-1:W/2]};
          OP_VSLLI: er = ea << cnt_i;
          OP_VSRLI: er = ea >> cnt_i;
          default:  er = '0;
        endcase
      end

      assign lane_res[g][l*W +: W] = er;
    end

    // Upper lane of each pair is the even element, lower lane the odd one.
    if (N > 1) begin : g_mul
      for (genvar k = 0; k < N / 2; k++) begin : g_pair
        assign mul_even[g][k*2*W +: 2*W] =
          (2*W)'(a[(2*k+1)*W +: W]) * (2*W)'(b[(2*k+1)*W +: W]);
        assign mul_odd[g][k*2*W +: 2*W] =
          (2*W)'(a[2*k*W +: W]) * (2*W)'(b[2*k*W +: W]);
      end
    end else begin : g_nomul
      assign mul_even[g] = '0;
      assign mul_odd[g]  = '0;
    end
  end

  always_comb begin
    result_d = lane_res[wsel];
    if (opc == OP_VMULEU) begin
      result_d = mul_even[wsel];
    end else if (opc == OP_VMULOU) begin
      result_d = mul_odd[wsel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vectors from the plan plus a pipelined random
// sweep against an element-wise arithmetic reference model.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [63:0] opr_a;
  logic [63:0] opr_b;
  logic [4:0]  sa;
  logic [5:0]  opv;
  logic [1:0]  wwv;
  logic [63:0] res;

  int n_vec;
  int n_err;

  alu_core #(.DW(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .oprA         (opr_a),
    .oprB         (opr_b),
    .shift_amount (sa),
    .op           (opv),
    .ww           (wwv),
    .result       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] A0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] B0 = 64'h0000000000000054;

  // Reference: extract each element by shifting, apply the rule, reassemble.
  function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] s, input logic [5:0] o,
                                            input logic [1:0] wsel);
    int unsigned w, n, pos, c, ci;
    logic [63:0] mask, x, y, r, acc;
    w   = 8 << wsel;
    n   = 64 / w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    acc = 64'd0;
    if (o >= 6'd16) return 64'd0;
    if (o == 6'd8 || o == 6'd9) begin
      if (w == 64) return 64'd0;
      for (int p = 0; p < int'(n / 2); p++) begin
        int e;
        e   = 2 * p + ((o == 6'd9) ? 1 : 0);
        pos = 64 - (e + 1) * w;
        x   = (a >> pos) & mask;
        y   = (b >> pos) & mask;
        acc = acc | ((x * y) << (64 - (p + 1) * 2 * w));
      end
      return acc;
    end
    for (int e = 0; e < int'(n); e++) begin
      pos = 64 - (e + 1) * w;
      x   = (a >> pos) & mask;
      y   = (b >> pos) & mask;
      c   = int'(y % 64'(w));
      ci  = int'(s) % w;
      case (o)
        6'd1:    r = x & y;
        6'd2:    r = x | y;
        6'd3:    r = x ^ y;
        6'd4:    r = ~x;
        6'd5:    r = x;
        6'd6:    r = x + y;
        6'd7:    r = x - y;
        6'd10:   r = x << c;
        6'd11:   r = x >> c;
        6'd12:   r = (x >> c) | ((((x >> (w - 1)) & 64'd1) != 0) ? (mask & ~(mask >> c)) : 64'd0);
        6'd13:   r = (x << (w / 2)) | (x >> (w / 2));
        6'd14:   r = x << ci;
        6'd15:   r = x >> ci;
        default: r = 64'd0;
      endcase
      acc = acc | ((r & mask) << pos);
    end
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive at negedge, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [63:0] a, input logic [63:0] b, input logic [4:0] s,
                      input logic [5:0] o, input logic [1:0] wsel,
                      input logic [63:0] exp, input string tag);
    @(negedge clk);
    opr_a = a; opr_b = b; sa = s; opv = o; wwv = wsel;
    @(posedge clk);
    #1;
    check(tag, res, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  logic [63:0] exp_q;
  bit          have_exp;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    opr_a = rnd64(); opr_b = rnd64(); sa = 5'($urandom()); opv = 6'd6; wwv = 2'd0;

    // Held in reset while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opr_a = rnd64(); opr_b = rnd64(); opv = 6'($urandom_range(1, 15)); wwv = 2'($urandom());
      @(posedge clk); #1;
      check("reset_hold", res, 64'd0);
    end

    @(negedge clk);
    opr_a = A0; opr_b = B0; sa = 5'd0; opv = 6'd1; wwv = 2'd0;
    rst_n = 1'b1;
    #1;
    check("pre_first_edge", res, 64'd0);
    @(posedge clk); #1;
    check("vand_first", res, 64'h0000000000000044);

    step(A0, B0, 5'd0, 6'd6,  2'd0, 64'h0123456789ABCD43, "vadd_b");
    step(A0, B0, 5'd0, 6'd6,  2'd3, 64'h0123456789ABCE43, "vadd_d");
    step(A0, B0, 5'd0, 6'd7,  2'd0, 64'h0123456789ABCD9B, "vsub_b");
    step(A0, B0, 5'd7, 6'd14, 2'd0, 64'h8080808080808080, "vslli_b7");
    step(A0, B0, 5'd4, 6'd15, 2'd3, 64'h00123456789ABCDE, "vsrli_d4");
    step(A0, B0, 5'd0, 6'd9,  2'd2, 64'h0000002D2C5F926C, "vmulou_w");
    step(A0, B0, 5'd0, 6'd8,  2'd2, 64'h0000000000000000, "vmuleu_w");
    step(A0, B0, 5'd0, 6'd8,  2'd3, 64'h0000000000000000, "vmuleu_d");
    step(A0, B0, 5'd0, 6'd13, 2'd2, 64'h45670123CDEF89AB, "vrtth_w");
    step(64'h8080808080808080, 64'h0101010101010101, 5'd0, 6'd12, 2'd0,
         64'hC0C0C0C0C0C0C0C0, "vsra_b");
    step(A0, B0, 5'd0, 6'd21, 2'd1, 64'h0000000000000000, "illegal_op");
    step(A0, 64'hFFFFFFFFFFFFFFFF, 5'd0, 6'd5, 2'd3, A0, "vmov");

    // Asynchronous clear mid-cycle, then recovery on the next edge.
    @(negedge clk);
    opr_a = A0; opr_b = B0; opv = 6'd4; wwv = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_vnot", res, ~A0);

    // Pipelined sweep: each cycle checks the previous cycle's vector.
    have_exp = 1'b0;
    for (int o = 0; o < 16; o++) begin
      for (int wv = 0; wv < 4; wv++) begin
        for (int rep = 0; rep < 6; rep++) begin
          @(negedge clk);
          if (have_exp) check("sweep", res, exp_q);
          opr_a = rnd64();
          opr_b = (rep < 2) ? 64'($urandom_range(0, 255)) * 64'h0101010101010101 : rnd64();
          sa    = 5'($urandom());
          opv   = 6'(o);
          wwv   = 2'(wv);
          exp_q = ref_model(opr_a, opr_b, sa, opv, wwv);
          have_exp = 1'b1;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("sweep_illegal", res, exp_q);
      opr_a = rnd64(); opr_b = rnd64(); sa = 5'($urandom());
      opv   = 6'($urandom_range(16, 63));
      wwv   = 2'($urandom());
      exp_q = ref_model(opr_a, opr_b, sa, opv, wwv);
    end
    @(negedge clk);
    check("sweep_last", res, exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 64-bit SIMD vector ALU for the execution stage of the project processor.
- Each operation applies to packed elements whose width is selected per operation by ww: bytes, halfwords, words or the full doubleword.
- The result is registered: one clock of latency, with an asynchronous active-low clear.
- Bit numbering is big-endian. Bit 0 is the MSB; element 0 occupies the most-significant bits.

Parameters:
- DW, 64, operand/result width; fixed, the only supported value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- oprA  input  [0:63]  operand A (rA).
- oprB  input  [0:63]  operand B (rB), or per-element shift/rotate counts.
- shift_amount  input  [0:4]  immediate shift count for the immediate-shift ops.
- op  input  [0:5]  operation select.
- ww  input  [0:1]  element width: 00 = 8-bit (8 elements), 01 = 16-bit (4), 10 = 32-bit (2), 11 = 64-bit (1).
- result  output  [0:63]  registered result.

Behaviour:
- Clocking and reset
  - rst_n low: result = 0 immediately, held while low.
  - Otherwise result <= f(oprA, oprB, shift_amount, op, ww) on every rising clk. There is no enable and no handshake.
  - Latency is exactly 1 cycle: inputs applied before edge N appear on result after edge N.
  - Reset deasserting mid-stream: the first valid result comes from the first rising edge with rst_n high.
- Width of operations: w = 8/16/32/64 per ww, applied element-wise with no carries, borrows or shifts crossing element boundaries.
- Opcodes:
  - 000000 VNOP: result 0.
  - 000001 VAND: A & B (ww ignored).
  - 000010 VOR: A | B.
  - 000011 VXOR: A ^ B.
  - 000100 VNOT: ~A.
  - 000101 VMOV: A.
  - 000110 VADD: A[i] + B[i] mod 2^w.
  - 000111 VSUB: A[i] - B[i] mod 2^w (two's complement wrap).
  - 001000 VMULEU: unsigned multiply of even elements (0,2,4,…) of A and B. Each 2w-bit product goes into the 2w-bit slot covering elements i and i+1.
  - 001001 VMULOU: same as VMULEU, using odd elements (1,3,…).
  - 001010 VSLL: A[i] << (B[i] mod w), zero fill.
  - 001011 VSRL: A[i] >> (B[i] mod w), zero fill.
  - 001100 VSRA: A[i] >> (B[i] mod w), sign fill from the element MSB.
  - 001101 VRTTH: swap the upper and lower halves of each element (ww=00 swaps nibbles).
  - 001110 VSLLI: A[i] << (shift_amount mod w).
  - 001111 VSRLI: A[i] >> (shift_amount mod w), zero fill.
- Shift counts
  - "mod w" keeps the low log2(w) bits of the count.
  - For ww=11, shift_amount supplies at most 31.
  - Count 0 leaves the element unchanged.
- Boundary cases
  - VMULEU/VMULOU with ww=11: result 0 (no 128-bit product).
  - Any op value 010000–111111: result 0.
  - All arithmetic is unsigned except VSRA. No flags and no overflow indication; overflow wraps silently.
- The datapath is purely combinational into a single 64-bit register; there is no other state.

Test Plan:
- Reset and logic ops
  - Stimulus: rst_n low with random inputs; then rst_n high, A=0x0123456789ABCDEF, B=0x54, op=000001, one edge.
  - Required: result = 0 while rst_n is low; 0x0000000000000044 after the edge; result holds 0 until that first edge.
- VADD by width
  - A as above, B=0x54, op=000110.
  - ww=00 -> 0x0123456789ABCD43 (no carry out of the byte).
  - ww=11 -> 0x0123456789ABCE43.
  - VSUB ww=00 -> 0x0123456789ABCD9B.
- Immediate shift masking
  - A as above, op=001110 (VSLLI), ww=00, shift_amount=7 -> 0x8080808080808080.
  - op=001111 (VSRLI), ww=11, shift_amount=4 -> 0x00123456789ABCDE.
- Multiply
  - A as above, B=0x54, op=001001 (VMULOU), ww=10 -> 0x0000002D2C5F926C.
  - op=001000 (VMULEU), ww=10 -> 0.
  - VMULEU with ww=11 -> 0.
- Rotate, arithmetic shift, illegal op
  - op=001101 (VRTTH), ww=10 -> 0x45670123CDEF89AB.
  - VSRA, ww=00, A=0x80..80, B=0x0101010101010101 -> 0xC0C0C0C0C0C0C0C0.
  - op=010101 -> 0.
- Full sweep: op 000000–001111 × all four ww values, checked against a reference model every cycle, with a 1-cycle result delay.
